mesi_mbus_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares a single main-memory bus between the per-CPU main-bus ports of the MESI coherence subsystem. Each CPU's cache controller presents a command, address and write data. The arbiter grants one port at a time, drives the memory bus until the memory acknowledges, returns read data, and pulses the granted port's acknowledge. It sits between the `mesi_isc` cache/CPU ports and the shared memory model.

---
 rtl/mesi_mbus_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_mesi_mbus_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mesi_mbus_arbiter.sv
// mesi_mbus_arbiter: round-robin sequencer sharing one main-memory bus among
// the per-CPU main-bus ports of the MESI subsystem.
// Optional feature: define MESI_MBUS_ARB_TIMEOUT_EN to abort WAIT after
// TIMEOUT_CYCLES cycles without mem_ack_i and raise a sticky timeout_o.
module mesi_mbus_arbiter #(
    parameter int unsigned NUM_PORTS      = 4,
    parameter int unsigned ID_WIDTH       = 2,
    parameter int unsigned CMD_WIDTH      = 3,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_PORTS*CMD_WIDTH-1:0]   req_cmd_i,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_data_i,
    output logic [NUM_PORTS-1:0]             req_ack_o,
    output logic [DATA_WIDTH-1:0]            rd_data_o,
    output logic [CMD_WIDTH-1:0]             mem_cmd_o,
    output logic [ADDR_WIDTH-1:0]            mem_addr_o,
    output logic [DATA_WIDTH-1:0]            mem_data_o,
    input  logic                             mem_ack_i,
    input  logic [DATA_WIDTH-1:0]            mem_data_i,
    output logic [ID_WIDTH-1:0]              grant_id_o,
    output logic                             busy_o,
    output logic                             timeout_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_e;

    // Reject parameter sets the grant id or timeout counter cannot represent
    if (ID_WIDTH != $clog2(NUM_PORTS) || NUM_PORTS < 2 || NUM_PORTS > 8 ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_param_chk
        $error("mesi_mbus_arbiter: illegal parameter combination");
    end

    logic [CMD_WIDTH-1:0]  cmd_a  [NUM_PORTS];
    logic [ADDR_WIDTH-1:0] addr_a [NUM_PORTS];
    logic [DATA_WIDTH-1:0] data_a [NUM_PORTS];

    // Unpack the flat per-port buses
    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
        assign cmd_a[g]  = req_cmd_i[g*CMD_WIDTH +: CMD_WIDTH];
        assign addr_a[g] = req_addr_i[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign data_a[g] = req_data_i[g*DATA_WIDTH +: DATA_WIDTH];
    end

    state_e                state_q, state_d;
    logic [CMD_WIDTH-1:0]  mem_cmd_q, mem_cmd_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic [ID_WIDTH-1:0]   grant_id_q, grant_id_d;
    logic [ID_WIDTH-1:0]   last_grant_q, last_grant_d;
    logic [NUM_PORTS-1:0]  req_ack_q, req_ack_d;
    logic                  busy_q, busy_d;
`ifdef MESI_MBUS_ARB_TIMEOUT_EN
    logic [7:0]            cnt_q, cnt_d;
    logic                  timeout_q, timeout_d;
`endif

    logic                  scan_hit;
    logic [ID_WIDTH-1:0]   scan_win;
    logic [ID_WIDTH-1:0]   scan_idx;

    // Round-robin scan starting one past the last winner, wrapping at NUM_PORTS
    always_comb begin
        scan_hit = 1'b0;
        scan_win = last_grant_q;
        scan_idx = last_grant_q;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            scan_idx = (scan_idx == ID_WIDTH'(NUM_PORTS - 1)) ? '0 : scan_idx + ID_WIDTH'(1);
            if (!scan_hit && cmd_a[scan_idx] != '0) begin
                scan_hit = 1'b1;
                scan_win = scan_idx;
            end
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        mem_cmd_d    = mem_cmd_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        rd_data_d    = rd_data_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        req_ack_d    = '0;
`ifdef MESI_MBUS_ARB_TIMEOUT_EN
        cnt_d        = cnt_q;
        timeout_d    = timeout_q;
`endif
        case (state_q)
            ST_IDLE: begin
                mem_cmd_d = '0;
                if (scan_hit) begin
                    mem_cmd_d    = cmd_a[scan_win];
                    mem_addr_d   = addr_a[scan_win];
                    mem_data_d   = data_a[scan_win];
                    grant_id_d   = scan_win;
                    last_grant_d = scan_win;
                    state_d      = ST_WAIT;
`ifdef MESI_MBUS_ARB_TIMEOUT_EN
                    cnt_d        = '0;
`endif
                end
            end
            ST_WAIT: begin
                if (mem_ack_i) begin
                    rd_data_d = mem_data_i;
                    mem_cmd_d = '0;
                    req_ack_d = NUM_PORTS'(1) << grant_id_q;
                    state_d   = ST_ACK;
                end
`ifdef MESI_MBUS_ARB_TIMEOUT_EN
                // This cycle is the TIMEOUT_CYCLES-th without an ack: abort
                else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
                    rd_data_d = '0;
                    mem_cmd_d = '0;
                    req_ack_d = NUM_PORTS'(1) << grant_id_q;
                    timeout_d = 1'b1;
                    state_d   = ST_ACK;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers, asynchronous active-high reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            mem_cmd_q    <= '0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            rd_data_q    <= '0;
            grant_id_q   <= '0;
            last_grant_q <= ID_WIDTH'(NUM_PORTS - 1);
            req_ack_q    <= '0;
            busy_q       <= 1'b0;
`ifdef MESI_MBUS_ARB_TIMEOUT_EN
            cnt_q        <= '0;
            timeout_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            mem_cmd_q    <= mem_cmd_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            rd_data_q    <= rd_data_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            req_ack_q    <= req_ack_d;
            busy_q       <= busy_d;
`ifdef MESI_MBUS_ARB_TIMEOUT_EN
            cnt_q        <= cnt_d;
            timeout_q    <= timeout_d;
`endif
        end
    end

    assign req_ack_o  = req_ack_q;
    assign rd_data_o  = rd_data_q;
    assign mem_cmd_o  = mem_cmd_q;
    assign mem_addr_o = mem_addr_q;
    assign mem_data_o = mem_data_q;
    assign grant_id_o = grant_id_q;
    assign busy_o     = busy_q;
`ifdef MESI_MBUS_ARB_TIMEOUT_EN
    assign timeout_o  = timeout_q;
`else
    assign timeout_o  = 1'b0;
`endif

endmodule

// File: tb/tb_mesi_mbus_arbiter.sv
// Directed self-checking bench for mesi_mbus_arbiter (4 ports).
module tb_mesi_mbus_arbiter;

    logic         clk;
    logic         rst;
    logic [11:0]  req_cmd_i;
    logic [127:0] req_addr_i;
    logic [127:0] req_data_i;
    logic [3:0]   req_ack_o;
    logic [31:0]  rd_data_o;
    logic [2:0]   mem_cmd_o;
    logic [31:0]  mem_addr_o;
    logic [31:0]  mem_data_o;
    logic         mem_ack_i;
    logic [31:0]  mem_data_i;
    logic [1:0]   grant_id_o;
    logic         busy_o;
    logic         timeout_o;

    logic [2:0]   tb_cmd  [4];
    logic [31:0]  tb_addr [4];
    logic [31:0]  tb_data [4];

    int passed = 0;
    int total  = 0;

    for (genvar g = 0; g < 4; g++) begin : g_pack
        assign req_cmd_i[g*3 +: 3]   = tb_cmd[g];
        assign req_addr_i[g*32 +: 32] = tb_addr[g];
        assign req_data_i[g*32 +: 32] = tb_data[g];
    end

    mesi_mbus_arbiter #(
        .NUM_PORTS(4), .ID_WIDTH(2), .CMD_WIDTH(3),
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk), .rst(rst),
        .req_cmd_i(req_cmd_i), .req_addr_i(req_addr_i), .req_data_i(req_data_i),
        .req_ack_o(req_ack_o), .rd_data_o(rd_data_o),
        .mem_cmd_o(mem_cmd_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
        .grant_id_o(grant_id_o), .busy_o(busy_o), .timeout_o(timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle: inputs change and outputs are sampled 1ns after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        for (int p = 0; p < 4; p++) begin
            tb_cmd[p]  = '0;
            tb_addr[p] = '0;
            tb_data[p] = '0;
        end
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (mem_cmd_o !== 3'd0)   $display("FAIL reset_mem_cmd got %0h exp 0", mem_cmd_o);   else passed++;
        total++; if (mem_addr_o !== 32'd0) $display("FAIL reset_mem_addr got %0h exp 0", mem_addr_o); else passed++;
        total++; if (mem_data_o !== 32'd0) $display("FAIL reset_mem_data got %0h exp 0", mem_data_o); else passed++;
        total++; if (req_ack_o !== 4'd0)   $display("FAIL reset_req_ack got %0b exp 0", req_ack_o);   else passed++;
        total++; if (rd_data_o !== 32'd0)  $display("FAIL reset_rd_data got %0h exp 0", rd_data_o);  else passed++;
        total++; if (grant_id_o !== 2'd0)  $display("FAIL reset_grant got %0d exp 0", grant_id_o);   else passed++;
        total++; if (busy_o !== 1'b0)      $display("FAIL reset_busy got %0b exp 0", busy_o);        else passed++;
        total++; if (timeout_o !== 1'b0)   $display("FAIL reset_timeout got %0b exp 0", timeout_o);  else passed++;
    endtask

    task automatic test_single_read();
        do_reset();
        tb_cmd[2] = 3'd2; tb_addr[2] = 32'h0000_1000;
        step(); // cycle 1
        total++; if (mem_cmd_o !== 3'd2)          $display("FAIL rd_c1_cmd got %0h exp 2", mem_cmd_o);           else passed++;
        total++; if (mem_addr_o !== 32'h1000)     $display("FAIL rd_c1_addr got %0h exp 1000", mem_addr_o);     else passed++;
        total++; if (grant_id_o !== 2'd2)         $display("FAIL rd_c1_grant got %0d exp 2", grant_id_o);        else passed++;
        total++; if (busy_o !== 1'b1)             $display("FAIL rd_c1_busy got %0b exp 1", busy_o);             else passed++;
        step(); // cycle 2
        total++; if (mem_cmd_o !== 3'd2)          $display("FAIL rd_c2_cmd got %0h exp 2", mem_cmd_o);           else passed++;
        total++; if (req_ack_o !== 4'd0)          $display("FAIL rd_c2_ack got %0b exp 0", req_ack_o);           else passed++;
        step(); // cycle 3
        mem_ack_i = 1'b1; mem_data_i = 32'hDEAD_BEEF;
        total++; if (mem_cmd_o !== 3'd2)          $display("FAIL rd_c3_cmd got %0h exp 2", mem_cmd_o);           else passed++;
        step(); // cycle 4
        mem_ack_i = 1'b0; mem_data_i = '0;
        total++; if (req_ack_o !== 4'b0100)       $display("FAIL rd_c4_ack got %0b exp 0100", req_ack_o);        else passed++;
        total++; if (rd_data_o !== 32'hDEAD_BEEF) $display("FAIL rd_c4_data got %0h exp deadbeef", rd_data_o);  else passed++;
        total++; if (mem_cmd_o !== 3'd0)          $display("FAIL rd_c4_cmd got %0h exp 0", mem_cmd_o);           else passed++;
        total++; if (busy_o !== 1'b1)             $display("FAIL rd_c4_busy got %0b exp 1", busy_o);             else passed++;
        step(); // cycle 5
        tb_cmd[2] = '0;
        total++; if (req_ack_o !== 4'd0)          $display("FAIL rd_c5_ack got %0b exp 0", req_ack_o);           else passed++;
        total++; if (busy_o !== 1'b0)             $display("FAIL rd_c5_busy got %0b exp 0", busy_o);             else passed++;
        total++; if (rd_data_o !== 32'hDEAD_BEEF) $display("FAIL rd_c5_data got %0h exp deadbeef", rd_data_o);  else passed++;
    endtask

    // All four ports at once, memory always acking: grants 0,1,2,3 three cycles apart
    task automatic test_all_ports();
        logic [3:0] exp_ack;
        do_reset();
        mem_ack_i  = 1'b1;
        mem_data_i = 32'hA0;
        for (int p = 0; p < 4; p++) begin
            tb_cmd[p]  = 3'(p + 1);
            tb_addr[p] = 32'(p * 256);
            tb_data[p] = 32'(p + 16);
        end
        for (int c = 1; c <= 12; c++) begin
            step();
            mem_data_i = 32'(32'hA0 + c);
            if (c % 3 == 0) tb_cmd[c/3 - 1] = '0;
            exp_ack = (c % 3 == 2) ? (4'b0001 << (c / 3)) : 4'b0000;
            total++; if (req_ack_o !== exp_ack) $display("FAIL all_ack c%0d got %0b exp %0b", c, req_ack_o, exp_ack); else passed++;
            if (c % 3 == 2) begin
                total++; if (grant_id_o !== 2'(c / 3)) $display("FAIL all_grant c%0d got %0d exp %0d", c, grant_id_o, c / 3); else passed++;
                total++; if (rd_data_o !== 32'(32'hA0 + c - 1)) $display("FAIL all_rd c%0d got %0h exp %0h", c, rd_data_o, 32'hA0 + c - 1); else passed++;
            end
            if (c % 3 == 1 && c < 12) begin
                total++; if (mem_cmd_o !== 3'(c / 3 + 1)) $display("FAIL all_cmd c%0d got %0d exp %0d", c, mem_cmd_o, c / 3 + 1); else passed++;
            end
        end
        mem_ack_i = 1'b0;
    endtask

    // Port 1 re-requests after its ack; waiting port 3 (and late port 0) go first
    task automatic test_fairness();
        logic [3:0] exp_ack;
        do_reset();
        mem_ack_i = 1'b1;
        tb_cmd[1] = 3'd3; tb_addr[1] = 32'h10;
        tb_cmd[3] = 3'd6; tb_addr[3] = 32'h30;
        for (int c = 1; c <= 11; c++) begin
            step();
            case (c)
                3: begin tb_cmd[1] = '0; tb_cmd[0] = 3'd1; end
                4: tb_cmd[1] = 3'd3;
                6: tb_cmd[3] = '0;
                9: tb_cmd[0] = '0;
                default: ;
            endcase
            case (c)
                2:  exp_ack = 4'b0010;
                5:  exp_ack = 4'b1000;
                8:  exp_ack = 4'b0001;
                11: exp_ack = 4'b0010;
                default: exp_ack = 4'b0000;
            endcase
            total++; if (req_ack_o !== exp_ack) $display("FAIL fair_ack c%0d got %0b exp %0b", c, req_ack_o, exp_ack); else passed++;
        end
        tb_cmd[1] = '0;
        mem_ack_i = 1'b0;
    endtask

    task automatic test_write();
        do_reset();
        tb_cmd[0] = 3'd1; tb_addr[0] = 32'h40; tb_data[0] = 32'h1234_5678;
        step(); // cycle 1
        total++; if (mem_cmd_o !== 3'd1)          $display("FAIL wr_c1_cmd got %0h exp 1", mem_cmd_o);           else passed++;
        tb_data[0] = 32'hFFFF_FFFF; tb_addr[0] = 32'h999;
        for (int c = 2; c <= 3; c++) begin
            step();
            total++; if (mem_addr_o !== 32'h40)        $display("FAIL wr_addr c%0d got %0h exp 40", c, mem_addr_o);       else passed++;
            total++; if (mem_data_o !== 32'h1234_5678) $display("FAIL wr_data c%0d got %0h exp 12345678", c, mem_data_o); else passed++;
        end
        mem_ack_i = 1'b1; mem_data_i = 32'h55;
        step(); // cycle 4
        mem_ack_i = 1'b0; mem_data_i = '0;
        total++; if (req_ack_o !== 4'b0001) $display("FAIL wr_c4_ack got %0b exp 0001", req_ack_o); else passed++;
        total++; if (rd_data_o !== 32'h55)  $display("FAIL wr_c4_rd got %0h exp 55", rd_data_o);   else passed++;
        step();
        tb_cmd[0] = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        tb_cmd[1] = 3'd3; tb_addr[1] = 32'h80;
        step();
        step(); // cycle 2, in WAIT
        total++; if (busy_o !== 1'b1)  $display("FAIL mid_pre_busy got %0b exp 1", busy_o);   else passed++;
        #2;
        rst = 1'b1;
        #1;
        total++; if (mem_cmd_o !== 3'd0)   $display("FAIL mid_async_cmd got %0h exp 0", mem_cmd_o);   else passed++;
        total++; if (mem_addr_o !== 32'd0) $display("FAIL mid_async_addr got %0h exp 0", mem_addr_o); else passed++;
        total++; if (busy_o !== 1'b0)      $display("FAIL mid_async_busy got %0b exp 0", busy_o);     else passed++;
        total++; if (grant_id_o !== 2'd0)  $display("FAIL mid_async_grant got %0d exp 0", grant_id_o); else passed++;
        mem_ack_i = 1'b1;
        step();
        step();
        total++; if (req_ack_o !== 4'd0)   $display("FAIL mid_no_ack got %0b exp 0", req_ack_o);      else passed++;
        rst = 1'b0; mem_ack_i = 1'b0;
        tb_cmd[1] = '0;
        tb_cmd[3] = 3'd5; tb_addr[3] = 32'hC0;
        step(); // cycle 1 after release
        total++; if (grant_id_o !== 2'd3)  $display("FAIL mid_p3_grant got %0d exp 3", grant_id_o);   else passed++;
        total++; if (mem_cmd_o !== 3'd5)   $display("FAIL mid_p3_cmd got %0h exp 5", mem_cmd_o);      else passed++;
        mem_ack_i = 1'b1;
        step();
        mem_ack_i = 1'b0;
        total++; if (req_ack_o !== 4'b1000) $display("FAIL mid_p3_ack got %0b exp 1000", req_ack_o);  else passed++;
        step();
        tb_cmd[3] = '0;
        total++; if (busy_o !== 1'b0)      $display("FAIL mid_p3_idle got %0b exp 0", busy_o);        else passed++;
    endtask

`ifdef MESI_MBUS_ARB_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        tb_cmd[2] = 3'd2; tb_addr[2] = 32'h200;
        for (int c = 1; c <= 4; c++) begin
            step();
            total++; if (req_ack_o !== 4'd0) $display("FAIL to_wait_ack c%0d got %0b exp 0", c, req_ack_o); else passed++;
        end
        step(); // cycle 5: aborted transaction acks
        total++; if (req_ack_o !== 4'b0100) $display("FAIL to_ack got %0b exp 0100", req_ack_o); else passed++;
        total++; if (rd_data_o !== 32'd0)   $display("FAIL to_rd got %0h exp 0", rd_data_o);     else passed++;
        total++; if (timeout_o !== 1'b1)    $display("FAIL to_flag got %0b exp 1", timeout_o);   else passed++;
        total++; if (mem_cmd_o !== 3'd0)    $display("FAIL to_cmd got %0h exp 0", mem_cmd_o);    else passed++;
        step();
        tb_cmd[2] = '0;
        step();
        total++; if (timeout_o !== 1'b1)    $display("FAIL to_sticky got %0b exp 1", timeout_o); else passed++;
        total++; if (busy_o !== 1'b0)       $display("FAIL to_idle got %0b exp 0", busy_o);      else passed++;
    endtask
`endif

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_single_read();
        test_all_ports();
        test_fairness();
        test_write();
        test_reset_mid();
`ifdef MESI_MBUS_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
